byte_serial_add_ctrl: RTL and testbench
=======================================

Name: byte_serial_add_ctrl

Overview:
- Sequencer that performs a wide add (default 32-bit) by reusing one 8-bit ripple full adder for NBYTES cycles.
- The carry is chained through a register from byte to byte.
- Sits between a command source (start/ready handshake) and downstream logic that consumes the result on a one-cycle done pulse.
- Reduces area wherever wide additions are infrequent.

Parameters:
- NBYTES, 4, number of 8-bit slices per operation (width W = 8*NBYTES); legal range 2..8.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  request; accepted only when ready=1.
- a  input  W  operand A, sampled on accepted start.
- b  input  W  operand B, sampled on accepted start.
- cin  input  1  carry-in, sampled on accepted start.
- ready  output  1  high when a start will be accepted (state IDLE or DONE).
- busy  output  1  high while in state ADD.
- done  output  1  one-cycle pulse; result/cout/ovf valid in that cycle and held afterwards.
- result  output  W  registered sum.
- cout  output  1  registered carry-out of the MSB slice.
- ovf  output  1  registered signed overflow.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - state=IDLE, idx=0, carry_r=0, op registers=0.
  - result=0, cout=0, ovf=0, done=0, busy=0.
  - ready=1 from the first cycle after reset.
  - Reset has priority over every other input.
- IDLE:
  - start=1 latches a_r=a, b_r=b, carry_r=cin, idx=0, and moves to ADD.
  - result is not cleared on start; it holds the previous value until overwritten slice by slice.
- ADD, one slice per cycle:
  - The adder sees a_r[8*idx+:8], b_r[8*idx+:8] and carry_r.
  - At the clock edge: result[8*idx+:8] <= sum8; carry_r <= cout8; idx <= idx+1.
  - When idx==NBYTES-1:
    - cout <= cout8.
    - ovf <= (a_r[W-1]==b_r[W-1]) && (sum8[7]!=a_r[W-1]).
    - Move to DONE.
  - start is ignored in ADD: no latch, no effect.
- DONE:
  - done=1 for exactly this cycle, then return to IDLE.
  - start=1 in DONE is accepted, with the same actions as in IDLE; next state is ADD, enabling back-to-back operations with no idle cycle.
- Latency: start accepted at edge k -> done high in the cycle after edge k+NBYTES (NBYTES+1 cycles from request).
- Throughput: one operation per NBYTES+1 cycles.
- done is a registered output: asserted on entry to DONE, deasserted on leaving.
- Arithmetic:
  - Unsigned modulo-2^W sum; cout is the true carry out of bit W-1.
  - ovf uses two's-complement interpretation.
  - Operands are frozen in a_r/b_r, so input changes during ADD have no effect.
- idx is a counter of width clog2(NBYTES); it returns to 0 on entry to IDLE or on an accepted start.
- Reset mid-ADD: the operation is aborted, no done pulse, all outputs cleared on that edge.

Decomposition:
- Shared package:
  - state encoding: IDLE=2'b00, ADD=2'b01, DONE=2'b10; 2'b11 recovers to IDLE.
  - constant SLICE_W=8.
- One sub-module: ripple_adder8, a combinational 8-bit ripple-carry adder.
  - Inputs: x[7:0], y[7:0], ci. Outputs: s[7:0], co.
  - Built from 1-bit full adders with the carry properly chained bit to bit.
  - Instantiated once; the controller muxes the operand slices into it.

Test Plan:
- Carry across a slice boundary: a=0x000000FF, b=0x00000001, cin=0 -> done 5 cycles after start; result=0x00000100, cout=0, ovf=0; busy high for exactly 4 cycles.
- Full carry ripple: a=0xFFFFFFFF, b=0x00000001, cin=0 -> result=0x00000000, cout=1, ovf=0. Repeat with a=0xFFFFFFFF, b=0, cin=1 -> same result.
- Signed overflow: a=0x7FFFFFFF, b=0x00000001 -> result=0x80000000, cout=0, ovf=1. Then a=0x80000000, b=0x80000000 -> result=0, cout=1, ovf=1.
- Start while busy: start with a=0x00000010, b=0x00000020; pulse start with a=0xAAAAAAAA, b=0x55555555 during ADD -> single done, result=0x00000030, ready=0 during ADD.
- Back-to-back: assert start in the DONE cycle with a=3, b=4 -> ready=1 in DONE, busy rises the next cycle, second done exactly 5 cycles later with result=7, no idle cycle between operations.
- Reset mid-operation: drop rst_n for one cycle at idx=2 of an add -> next cycle result=0, cout=0, ovf=0, done=0, busy=0, ready=1; no done pulse; a following add of 1+1 yields result=2.

Source files
------------

// File: rtl/byte_serial_add_ctrl_pkg.sv
// Shared types and constants for the byte-serial wide adder controller.
package byte_serial_add_ctrl_pkg;

    // Width of one adder slice; the wide add is walked through in steps of this size.
    localparam int SLICE_W = 8;

    // Controller states; the unused code 2'b11 falls back to IDLE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ADD  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // A new command can be taken while idle or in the final result cycle.
    function automatic logic accepts_start(state_e s);
        return (s == ST_IDLE) || (s == ST_DONE);
    endfunction

endpackage

// File: rtl/byte_serial_add_ctrl_ripple_adder8.sv
// Combinational 8-bit ripple-carry adder built from chained 1-bit full adders.
module ripple_adder8
    import byte_serial_add_ctrl_pkg::*;
(
    input  logic [SLICE_W-1:0] x,
    input  logic [SLICE_W-1:0] y,
    input  logic               ci,
    output logic [SLICE_W-1:0] s,
    output logic               co
);

    logic [SLICE_W:0] c;

    assign c[0] = ci;

    // One full adder per bit, carry handed from bit i to bit i+1.
    for (genvar i = 0; i < SLICE_W; i++) begin : g_fa
        assign s[i]   = x[i] ^ y[i] ^ c[i];
        assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end

    assign co = c[SLICE_W];

endmodule

// File: rtl/byte_serial_add_ctrl.sv
// Wide adder that reuses one 8-bit ripple adder over NBYTES cycles, chaining the
// carry through a register and reporting the finished sum with a one-cycle done pulse.
module byte_serial_add_ctrl
    import byte_serial_add_ctrl_pkg::*;
#(
    parameter int NBYTES = 4
)
(
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [SLICE_W*NBYTES-1:0]   a,
    input  logic [SLICE_W*NBYTES-1:0]   b,
    input  logic                        cin,
    output logic                        ready,
    output logic                        busy,
    output logic                        done,
    output logic [SLICE_W*NBYTES-1:0]   result,
    output logic                        cout,
    output logic                        ovf
);

    localparam int W     = SLICE_W * NBYTES;
    localparam int IDX_W = $clog2(NBYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    state_e           state_q,  state_d;
    logic [IDX_W-1:0] idx_q,    idx_d;
    logic             carry_q,  carry_d;
    logic [W-1:0]     a_q,      a_d;
    logic [W-1:0]     b_q,      b_d;
    logic [W-1:0]     result_q, result_d;
    logic             cout_q,   cout_d;
    logic             ovf_q,    ovf_d;
    logic             done_q,   done_d;
    logic             busy_q,   busy_d;
    logic             ready_q,  ready_d;

    logic [SLICE_W-1:0] slice_a;
    logic [SLICE_W-1:0] slice_b;
    logic [SLICE_W-1:0] sum8;
    logic               cout8;

    assign slice_a = a_q[idx_q*SLICE_W +: SLICE_W];
    assign slice_b = b_q[idx_q*SLICE_W +: SLICE_W];

    ripple_adder8 u_adder (
        .x  (slice_a),
        .y  (slice_b),
        .ci (carry_q),
        .s  (sum8),
        .co (cout8)
    );

    // Next-state logic: latch operands on an accepted start, then fold in one slice per cycle.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                idx_d = '0;
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    state_d = ST_ADD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ADD: begin
                result_d[idx_q*SLICE_W +: SLICE_W] = sum8;
                carry_d = cout8;
                idx_d   = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    cout_d  = cout8;
                    ovf_d   = (a_q[W-1] == b_q[W-1]) && (sum8[SLICE_W-1] != a_q[W-1]);
                    idx_d   = '0;
                    state_d = ST_DONE;
                end
            end
            default: begin
                idx_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
        done_d  = (state_d == ST_DONE);
        busy_d  = (state_d == ST_ADD);
        ready_d = accepts_start(state_d);
    end

    // State and output registers; reset clears everything and leaves the block ready.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            ready_q  <= ready_d;
        end
    end

    assign ready  = ready_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign cout   = cout_q;
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_byte_serial_add_ctrl.sv
// Directed self-checking bench for the byte-serial adder controller (NBYTES=4).
module tb_byte_serial_add_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic        cin_in;
    logic        ready;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        cout;
    logic        ovf;

    int checks   = 0;
    int failures = 0;

    byte_serial_add_ctrl #(.NBYTES(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a      (a_in),
        .b      (b_in),
        .cin    (cin_in),
        .ready  (ready),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout),
        .ovf    (ovf)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the directed sequence ever stalls.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Compare one observed value against its hand-computed expectation.
    task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Issue one start from a negedge and follow it until done, bounded to 20 cycles.
    task automatic apply_stimulus(input logic [31:0] av, input logic [31:0] bv, input logic cv,
                                  output int lat, output int busy_cnt, output logic busy_first);
        a_in       = av;
        b_in       = bv;
        cin_in     = cv;
        start      = 1'b1;
        lat        = -1;
        busy_cnt   = 0;
        busy_first = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (i == 1) busy_first = busy;
            if (busy) busy_cnt++;
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    initial begin
        int   lat;
        int   bcnt;
        logic bfirst;
        int   done_cnt;
        logic [31:0] res_cap;

        rst_n  = 1'b0;
        start  = 1'b0;
        a_in   = '0;
        b_in   = '0;
        cin_in = 1'b0;
        repeat (2) @(negedge clk);
        check_output("rst_ready",  ready,  1);
        check_output("rst_busy",   busy,   0);
        check_output("rst_done",   done,   0);
        check_output("rst_result", result, 0);
        check_output("rst_cout",   cout,   0);
        check_output("rst_ovf",    ovf,    0);
        rst_n = 1'b1;
        @(negedge clk);

        // Carry from byte 0 into byte 1.
        apply_stimulus(32'h000000FF, 32'h00000001, 1'b0, lat, bcnt, bfirst);
        check_output("slice_lat",    lat,    5);
        check_output("slice_busy",   bcnt,   4);
        check_output("slice_result", result, 32'h00000100);
        check_output("slice_cout",   cout,   0);
        check_output("slice_ovf",    ovf,    0);
        @(negedge clk);
        check_output("slice_done_low", done,   0);
        check_output("slice_hold",     result, 32'h00000100);
        check_output("slice_ready",    ready,  1);

        // Carry rippling through every slice.
        apply_stimulus(32'hFFFFFFFF, 32'h00000001, 1'b0, lat, bcnt, bfirst);
        check_output("ripple_lat",    lat,    5);
        check_output("ripple_result", result, 32'h00000000);
        check_output("ripple_cout",   cout,   1);
        check_output("ripple_ovf",    ovf,    0);
        @(negedge clk);

        // Same ripple driven purely from carry-in.
        apply_stimulus(32'hFFFFFFFF, 32'h00000000, 1'b1, lat, bcnt, bfirst);
        check_output("cin_lat",    lat,    5);
        check_output("cin_result", result, 32'h00000000);
        check_output("cin_cout",   cout,   1);
        check_output("cin_ovf",    ovf,    0);
        @(negedge clk);

        // Positive overflow.
        apply_stimulus(32'h7FFFFFFF, 32'h00000001, 1'b0, lat, bcnt, bfirst);
        check_output("povf_result", result, 32'h80000000);
        check_output("povf_cout",   cout,   0);
        check_output("povf_ovf",    ovf,    1);
        @(negedge clk);

        // Start pulsed during ADD must be ignored.
        a_in   = 32'h00000010;
        b_in   = 32'h00000020;
        cin_in = 1'b0;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_output("sb_ready_c1", ready, 0);
        check_output("sb_busy_c1",  busy,  1);
        @(negedge clk);
        check_output("sb_ready_c2", ready, 0);
        a_in   = 32'hAAAAAAAA;
        b_in   = 32'h55555555;
        cin_in = 1'b1;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_output("sb_ready_c3", ready, 0);
        done_cnt = 0;
        lat      = -1;
        res_cap  = '0;
        for (int i = 4; i <= 14; i++) begin
            @(negedge clk);
            if (done) begin
                done_cnt++;
                if (lat < 0) begin
                    lat     = i;
                    res_cap = result;
                end
            end
        end
        check_output("sb_lat",       lat,      5);
        check_output("sb_done_cnt",  done_cnt, 1);
        check_output("sb_result",    res_cap,  32'h00000030);

        // Back-to-back: second start issued in the DONE cycle of the first.
        apply_stimulus(32'h00000001, 32'h00000002, 1'b0, lat, bcnt, bfirst);
        check_output("b2b_first_result", result, 32'h00000003);
        check_output("b2b_ready_done",   ready,  1);
        apply_stimulus(32'h00000003, 32'h00000004, 1'b0, lat, bcnt, bfirst);
        check_output("b2b_busy_first", bfirst, 1);
        check_output("b2b_lat",        lat,    5);
        check_output("b2b_busy_cnt",   bcnt,   4);
        check_output("b2b_result",     result, 32'h00000007);
        @(negedge clk);

        // Negative overflow, which also leaves cout/ovf set for the reset test.
        apply_stimulus(32'h80000000, 32'h80000000, 1'b0, lat, bcnt, bfirst);
        check_output("novf_result", result, 32'h00000000);
        check_output("novf_cout",   cout,   1);
        check_output("novf_ovf",    ovf,    1);
        @(negedge clk);

        // Reset while idx==2 aborts the operation.
        a_in   = 32'h11111111;
        b_in   = 32'h22222222;
        cin_in = 1'b0;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_output("mid_partial", result, 32'h00003333);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_output("mid_result", result, 0);
        check_output("mid_cout",   cout,   0);
        check_output("mid_ovf",    ovf,    0);
        check_output("mid_done",   done,   0);
        check_output("mid_busy",   busy,   0);
        check_output("mid_ready",  ready,  1);
        done_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check_output("mid_no_done", done_cnt, 0);
        apply_stimulus(32'h00000001, 32'h00000001, 1'b0, lat, bcnt, bfirst);
        check_output("after_lat",    lat,    5);
        check_output("after_result", result, 32'h00000002);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
